bc_score_unit: RTL and testbench

- Scoring stage directly downstream of the guess/secret entry FSM in the Bulls-and-Cows game.
- When the FSM enters its result phase, this block snapshots the four secret digits and four guess digits and scores them serially over four cycles. It produces A (right digit, right place) and B (right digit, wrong place).
- Count A feeds back to the FSM's win check.
- Each scored turn goes into a circular history buffer that the display logic can read.

---
 rtl/bc_pkg.sv | 28 ++
 rtl/bc_score_history.sv | 82 ++++++++
 rtl/bc_score_unit.sv | 162 ++++++++++++++++
 tb/tb_bc_score_unit.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/bc_pkg.sv
// Shared types and constants for the Bulls-and-Cows scoring slice.
package bc_pkg;

    localparam logic [3:0] DIGIT_EMPTY = 4'hA;
    localparam int         NUM_DIGITS  = 4;

    typedef logic [3:0] digit_t;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        PUBLISH
    } score_state_t;

    typedef struct packed {
        logic [15:0] guess;
        logic [2:0]  a;
        logic [2:0]  b;
        logic [2:0]  turn;
    } hist_entry_t;

    // A digit may take part in a match only if it is a real decimal digit;
    // the empty marker and every code above 9 never match anything.
    function automatic logic is_digit(input digit_t d);
        return (d != DIGIT_EMPTY) && (d <= 4'd9);
    endfunction

endpackage

// File: rtl/bc_score_history.sv
// Circular history of scored turns: one write port, per-slot valid bits,
// saturating entry count and a registered read port.
module bc_score_history
    import bc_pkg::*;
#(
    parameter int HIST_DEPTH = 8,
    parameter int HIDX_W     = $clog2(HIST_DEPTH)
) (
    input  logic              clk,
    input  logic              RESET_N,
    input  logic              clear,
    input  logic              wr_en,
    input  hist_entry_t       wr_entry,
    output logic [HIDX_W:0]   hist_count,
    input  logic [HIDX_W-1:0] rd_idx,
    output hist_entry_t       rd_entry,
    output logic              rd_valid
);

    localparam logic [HIDX_W:0] COUNT_FULL = (HIDX_W+1)'(HIST_DEPTH);

    hist_entry_t             mem_reg [0:HIST_DEPTH-1];
    logic [HIST_DEPTH-1:0]   valid_reg;
    logic [HIDX_W-1:0]       wr_ptr_reg;
    logic [HIDX_W:0]         count_reg;
    hist_entry_t             rd_entry_reg;
    logic                    rd_valid_reg;
    logic                    wr_fire;

    // Clear wins over a same-cycle write.
    assign wr_fire = wr_en && !clear;

    // Entry storage kept reset-free so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (wr_fire)
            mem_reg[wr_ptr_reg] <= wr_entry;
    end

    // One valid bit per slot, set on write and wiped by clear.
    for (genvar gi = 0; gi < HIST_DEPTH; gi++) begin : g_valid
        always_ff @(posedge clk or negedge RESET_N) begin
            if (!RESET_N)
                valid_reg[gi] <= 1'b0;
            else if (clear)
                valid_reg[gi] <= 1'b0;
            else if (wr_fire && (wr_ptr_reg == HIDX_W'(gi)))
                valid_reg[gi] <= 1'b1;
        end
    end

    // Write pointer wraps naturally (depth is a power of two); count saturates at full.
    always_ff @(posedge clk or negedge RESET_N) begin
        if (!RESET_N) begin
            wr_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (clear) begin
            wr_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (wr_fire) begin
            wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (count_reg != COUNT_FULL)
                count_reg <= count_reg + 1'b1;
        end
    end

    // Registered read, one cycle behind rd_idx.
    always_ff @(posedge clk or negedge RESET_N) begin
        if (!RESET_N) begin
            rd_entry_reg <= '0;
            rd_valid_reg <= 1'b0;
        end else begin
            rd_entry_reg <= mem_reg[rd_idx];
            rd_valid_reg <= valid_reg[rd_idx];
        end
    end

    // Invalid slots read as all-zero data so stale RAM contents never leak out.
    assign rd_entry   = rd_valid_reg ? rd_entry_reg : '0;
    assign rd_valid   = rd_valid_reg;
    assign hist_count = count_reg;

endmodule

// File: rtl/bc_score_unit.sv
// Bulls-and-Cows scoring stage: snapshots secret/guess on a calc_req rise,
// scores one guess digit per cycle, publishes A/B and logs the turn.
module bc_score_unit
    import bc_pkg::*;
#(
    parameter int HIST_DEPTH = 8,
    parameter int HIDX_W     = $clog2(HIST_DEPTH)
) (
    input  logic              clk,
    input  logic              RESET_N,
    input  logic              clear,
    input  logic              calc_req,
    input  digit_t            secret [0:NUM_DIGITS-1],
    input  digit_t            guess  [0:NUM_DIGITS-1],
    input  logic [2:0]        turn_in,
    output logic [2:0]        count_a,
    output logic [2:0]        count_b,
    output logic              busy,
    output logic              done,
    output logic [HIDX_W:0]   hist_count,
    input  logic [HIDX_W-1:0] hist_rd_idx,
    output logic [15:0]       hist_rd_guess,
    output logic [2:0]        hist_rd_a,
    output logic [2:0]        hist_rd_b,
    output logic [2:0]        hist_rd_turn,
    output logic              hist_rd_valid
);

    score_state_t state_reg;
    logic         calc_req_q;
    digit_t       sec_reg [0:NUM_DIGITS-1];
    digit_t       gss_reg [0:NUM_DIGITS-1];
    logic [2:0]   turn_reg;
    logic [1:0]   idx_reg;
    logic [2:0]   acc_a_reg;
    logic [2:0]   acc_b_reg;
    logic [2:0]   count_a_reg;
    logic [2:0]   count_b_reg;
    logic         busy_reg;
    logic         done_reg;

    logic                  rise;
    digit_t                cur_g;
    logic [NUM_DIGITS-1:0] other_match;
    logic                  hit_a;
    logic                  hit_b;
    logic                  wr_en;
    hist_entry_t           wr_entry;
    hist_entry_t           rd_entry;

    assign rise  = calc_req & ~calc_req_q;
    assign cur_g = gss_reg[idx_reg];

    // Compare the current guess digit against every secret digit in another position.
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_match
        assign other_match[gi] = (idx_reg != 2'(gi)) && (sec_reg[gi] == cur_g);
    end

    assign hit_a = is_digit(cur_g) && (sec_reg[idx_reg] == cur_g);
    assign hit_b = is_digit(cur_g) && (|other_match);

    // Scoring FSM: snapshot on rise, four scan cycles, one publish cycle.
    always_ff @(posedge clk or negedge RESET_N) begin
        if (!RESET_N) begin
            state_reg   <= IDLE;
            calc_req_q  <= 1'b0;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                sec_reg[i] <= '0;
                gss_reg[i] <= '0;
            end
            turn_reg    <= '0;
            idx_reg     <= '0;
            acc_a_reg   <= '0;
            acc_b_reg   <= '0;
            count_a_reg <= '0;
            count_b_reg <= '0;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
        end else begin
            calc_req_q <= calc_req;
            done_reg   <= 1'b0;
            if (clear) begin
                state_reg   <= IDLE;
                busy_reg    <= 1'b0;
                count_a_reg <= '0;
                count_b_reg <= '0;
                acc_a_reg   <= '0;
                acc_b_reg   <= '0;
            end else begin
                case (state_reg)
                    IDLE: begin
                        if (rise) begin
                            sec_reg     <= secret;
                            gss_reg     <= guess;
                            turn_reg    <= turn_in;
                            acc_a_reg   <= '0;
                            acc_b_reg   <= '0;
                            count_a_reg <= '0;
                            count_b_reg <= '0;
                            idx_reg     <= 2'd3;
                            busy_reg    <= 1'b1;
                            state_reg   <= SCAN;
                        end
                    end
                    SCAN: begin
                        if (hit_a)
                            acc_a_reg <= acc_a_reg + 3'd1;
                        else if (hit_b)
                            acc_b_reg <= acc_b_reg + 3'd1;
                        if (idx_reg == 2'd0)
                            state_reg <= PUBLISH;
                        else
                            idx_reg <= idx_reg - 2'd1;
                    end
                    PUBLISH: begin
                        count_a_reg <= acc_a_reg;
                        count_b_reg <= acc_b_reg;
                        done_reg    <= 1'b1;
                        busy_reg    <= 1'b0;
                        state_reg   <= IDLE;
                    end
                    default: state_reg <= IDLE;
                endcase
            end
        end
    end

    // History entry is written on the publish cycle unless a clear lands on it.
    always_comb begin
        wr_en          = (state_reg == PUBLISH) && !clear;
        wr_entry       = '0;
        wr_entry.guess = {gss_reg[3], gss_reg[2], gss_reg[1], gss_reg[0]};
        wr_entry.a     = acc_a_reg;
        wr_entry.b     = acc_b_reg;
        wr_entry.turn  = turn_reg;
    end

    bc_score_history #(
        .HIST_DEPTH (HIST_DEPTH),
        .HIDX_W     (HIDX_W)
    ) u_history (
        .clk        (clk),
        .RESET_N    (RESET_N),
        .clear      (clear),
        .wr_en      (wr_en),
        .wr_entry   (wr_entry),
        .hist_count (hist_count),
        .rd_idx     (hist_rd_idx),
        .rd_entry   (rd_entry),
        .rd_valid   (hist_rd_valid)
    );

    assign count_a       = count_a_reg;
    assign count_b       = count_b_reg;
    assign busy          = busy_reg;
    assign done          = done_reg;
    assign hist_rd_guess = rd_entry.guess;
    assign hist_rd_a     = rd_entry.a;
    assign hist_rd_b     = rd_entry.b;
    assign hist_rd_turn  = rd_entry.turn;

endmodule

// File: tb/tb_bc_score_unit.sv
// Directed bench for bc_score_unit: vector table for scoring plus
// hand-written sequences for retrigger, wrap, clear and reset cases.
module tb_bc_score_unit;
    import bc_pkg::*;

    localparam int HD = 8;
    localparam int HW = 3;

    logic          clk = 1'b0;
    logic          RESET_N = 1'b0;
    logic          clear = 1'b0;
    logic          calc_req = 1'b0;
    digit_t        secret [0:3];
    digit_t        guess  [0:3];
    logic [2:0]    turn_in = '0;
    logic [2:0]    count_a, count_b;
    logic          busy, done;
    logic [HW:0]   hist_count;
    logic [HW-1:0] hist_rd_idx = '0;
    logic [15:0]   hist_rd_guess;
    logic [2:0]    hist_rd_a, hist_rd_b, hist_rd_turn;
    logic          hist_rd_valid;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [15:0] s;
        logic [15:0] g;
        logic [2:0]  turn;
        int          ea;
        int          eb;
    } vec_t;

    vec_t vecs [8];

    bc_score_unit #(.HIST_DEPTH(HD), .HIDX_W(HW)) dut (
        .clk           (clk),
        .RESET_N       (RESET_N),
        .clear         (clear),
        .calc_req      (calc_req),
        .secret        (secret),
        .guess         (guess),
        .turn_in       (turn_in),
        .count_a       (count_a),
        .count_b       (count_b),
        .busy          (busy),
        .done          (done),
        .hist_count    (hist_count),
        .hist_rd_idx   (hist_rd_idx),
        .hist_rd_guess (hist_rd_guess),
        .hist_rd_a     (hist_rd_a),
        .hist_rd_b     (hist_rd_b),
        .hist_rd_turn  (hist_rd_turn),
        .hist_rd_valid (hist_rd_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Packed {d3,d2,d1,d0} -> unpacked digit arrays.
    task automatic set_digits(input logic [15:0] s, input logic [15:0] g);
        for (int j = 0; j < 4; j++) begin
            secret[j] = s[j*4 +: 4];
            guess[j]  = g[j*4 +: 4];
        end
    endtask

    // One full scoring: pulse, check scan window, check publish and hold.
    task automatic score(input logic [15:0] s, input logic [15:0] g, input logic [2:0] t,
                         input int ea, input int eb, input string tag);
        set_digits(s, g);
        turn_in  = t;
        calc_req = 1'b1;
        tick();
        chk({tag, " busy@k"}, busy, 1);
        calc_req = 1'b0;
        set_digits(16'h9999, 16'h9999);
        turn_in = ~t;
        for (int c = 1; c <= 4; c++) begin
            tick();
            chk($sformatf("%s busy@k+%0d", tag, c), busy, 1);
            chk($sformatf("%s done@k+%0d", tag, c), done, 0);
            chk($sformatf("%s a_scan@k+%0d", tag, c), count_a, 0);
            chk($sformatf("%s b_scan@k+%0d", tag, c), count_b, 0);
        end
        tick();
        chk({tag, " done@k+5"}, done, 1);
        chk({tag, " busy@k+5"}, busy, 0);
        chk({tag, " count_a"}, count_a, ea);
        chk({tag, " count_b"}, count_b, eb);
        tick();
        chk({tag, " done_drop"}, done, 0);
        chk({tag, " a_hold"}, count_a, ea);
        chk({tag, " b_hold"}, count_b, eb);
    endtask

    task automatic read_slot(input int idx, input int ev, input logic [15:0] eg,
                             input int ea, input int eb, input int et, input string tag);
        hist_rd_idx = HW'(idx);
        tick();
        chk($sformatf("%s slot%0d valid", tag, idx), hist_rd_valid, ev);
        chk($sformatf("%s slot%0d guess", tag, idx), hist_rd_guess, eg);
        chk($sformatf("%s slot%0d a", tag, idx), hist_rd_a, ea);
        chk($sformatf("%s slot%0d b", tag, idx), hist_rd_b, eb);
        chk($sformatf("%s slot%0d turn", tag, idx), hist_rd_turn, et);
    endtask

    task automatic run_count(input int n, output int dones, output int busy_cycles);
        dones = 0;
        busy_cycles = 0;
        for (int c = 0; c < n; c++) begin
            tick();
            if (done) dones++;
            if (busy) busy_cycles++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int dn, bc, exp_cnt;

        set_digits(16'h0000, 16'h0000);

        // Hand-computed vectors: s/g are {d3,d2,d1,d0}, d3 scored first.
        vecs[0] = '{16'h1234, 16'h1234, 3'd0, 4, 0};
        vecs[1] = '{16'h1234, 16'h4321, 3'd1, 0, 4};
        vecs[2] = '{16'h1234, 16'h1243, 3'd2, 2, 2};
        vecs[3] = '{16'h1234, 16'h5678, 3'd3, 0, 0};
        vecs[4] = '{16'hAAAA, 16'hAAAA, 3'd4, 0, 0};
        vecs[5] = '{16'h1234, 16'h1AAA, 3'd5, 1, 0};
        vecs[6] = '{16'h1234, 16'h2999, 3'd6, 0, 1};
        vecs[7] = '{16'hF234, 16'hF000, 3'd7, 0, 0};

        // Reset state
        #12;
        chk("rst count_a", count_a, 0);
        chk("rst count_b", count_b, 0);
        chk("rst busy", busy, 0);
        chk("rst done", done, 0);
        chk("rst hist_count", hist_count, 0);
        chk("rst rd_valid", hist_rd_valid, 0);
        chk("rst rd_guess", hist_rd_guess, 0);
        @(negedge clk);
        RESET_N = 1'b1;
        tick();

        // Table-driven scoring and history fill
        for (int i = 0; i < 8; i++) begin
            score(vecs[i].s, vecs[i].g, vecs[i].turn, vecs[i].ea, vecs[i].eb,
                  $sformatf("vec%0d", i));
            exp_cnt = (i + 1 > HD) ? HD : i + 1;
            chk($sformatf("vec%0d hist_count", i), hist_count, exp_cnt);
            read_slot(i, 1, vecs[i].g, vecs[i].ea, vecs[i].eb, vecs[i].turn, "fill");
        end

        // Ninth entry wraps onto slot 0
        score(16'h1234, 16'h4123, 3'd0, 0, 4, "wrap");
        chk("wrap hist_count", hist_count, 8);
        read_slot(0, 1, 16'h4123, 0, 4, 0, "wrap");
        read_slot(1, 1, 16'h4321, 0, 4, 1, "wrap");

        // calc_req held high: exactly one scoring
        set_digits(16'h1234, 16'h1234);
        calc_req = 1'b1;
        run_count(20, dn, bc);
        calc_req = 1'b0;
        tick();
        chk("hold dones", dn, 1);
        chk("hold busy_cycles", bc, 5);
        chk("hold count_a", count_a, 4);

        // Clear wipes counts and history
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("clear hist_count", hist_count, 0);
        chk("clear count_a", count_a, 0);
        chk("clear busy", busy, 0);
        read_slot(0, 0, 16'h0000, 0, 0, 0, "clear");

        // Re-rise during scan is ignored
        set_digits(16'h1234, 16'h4321);
        turn_in  = 3'd2;
        calc_req = 1'b1;
        tick();
        calc_req = 1'b0;
        tick();
        calc_req = 1'b1;
        run_count(18, dn, bc);
        calc_req = 1'b0;
        tick();
        chk("toggle dones", dn, 1);
        chk("toggle hist_count", hist_count, 1);
        chk("toggle count_b", count_b, 4);

        // Clear at k+2 aborts the scan
        set_digits(16'h1234, 16'h1234);
        calc_req = 1'b1;
        tick();
        calc_req = 1'b0;
        tick();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("abort busy", busy, 0);
        run_count(10, dn, bc);
        chk("abort dones", dn, 0);
        chk("abort busy_cycles", bc, 0);
        chk("abort hist_count", hist_count, 0);
        for (int s = 0; s < HD; s++)
            read_slot(s, 0, 16'h0000, 0, 0, 0, "abort");

        // Clear coincident with a rise stays idle
        calc_req = 1'b1;
        clear    = 1'b1;
        tick();
        clear = 1'b0;
        chk("clr_rise busy", busy, 0);
        run_count(8, dn, bc);
        chk("clr_rise dones", dn, 0);
        chk("clr_rise busy_cycles", bc, 0);
        calc_req = 1'b0;
        tick();

        // Asynchronous reset mid-scan
        score(16'h1234, 16'h1234, 3'd3, 4, 0, "prerst");
        hist_rd_idx = '0;
        tick();
        calc_req = 1'b1;
        tick();
        calc_req = 1'b0;
        tick();
        tick();
        chk("prerst busy", busy, 1);
        chk("prerst rd_valid", hist_rd_valid, 1);
        #2;
        RESET_N = 1'b0;
        #1;
        chk("arst busy", busy, 0);
        chk("arst done", done, 0);
        chk("arst count_a", count_a, 0);
        chk("arst hist_count", hist_count, 0);
        chk("arst rd_valid", hist_rd_valid, 0);
        chk("arst rd_guess", hist_rd_guess, 0);
        #3;
        RESET_N = 1'b1;
        tick();
        chk("post_rst hist_count", hist_count, 0);
        chk("post_rst busy", busy, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
